// File: rtl/count_compare_unit_if.sv
// Count/compare bus between the free-running counter side and the compare unit.
// The master drives count and control; the slave returns PWM, pulses and status.
interface count_compare_unit_if #(
  parameter int N      = 8,
  parameter int WRAP_W = 16
);
  logic [N-1:0]      count;
  logic              enable;
  logic              cmp_wr;
  logic [N-1:0]      cmp_val;
  logic              irq_clr;
  logic              pwm_out;
  logic              match_pulse;
  logic              wrap_pulse;
  logic              irq;
  logic [WRAP_W-1:0] wrap_cnt;
  logic [N-1:0]      cmp_active;

  modport master (
    output count, enable, cmp_wr, cmp_val, irq_clr,
    input  pwm_out, match_pulse, wrap_pulse, irq,
    input  wrap_cnt, cmp_active
  );

  modport slave (
    input  count, enable, cmp_wr, cmp_val, irq_clr,
    output pwm_out, match_pulse, wrap_pulse, irq,
    output wrap_cnt, cmp_active
  );
endinterface

// File: rtl/count_compare_unit.sv
// Compare/PWM stage: wrap detect, wrap counter, double-buffered compare, PWM, irq.
// Optional macro CCU_WRAP_IRQ_EN: wrap events also set the sticky irq.
module count_compare_unit #(
  parameter int N      = 8,
  parameter int WRAP_W = 16
) (
  input logic               clk,
  input logic               rst,
  count_compare_unit_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    ARMED,
    MATCHED
  } state_e;

  state_e            state_q, state_d;
  logic [N-1:0]      count_q;
  logic              valid_q;
  logic [N-1:0]      shadow_q;
  logic [N-1:0]      active_q;
  logic [N-1:0]      next_cmp;
  logic [WRAP_W-1:0] wcnt_q;
  logic              pwm_q, pwm_d;
  logic              match_q, match_d;
  logic              wrap_q;
  logic              irq_q, irq_d;
  logic              irq_set;
  logic              wrap_w;

  assign wrap_w = valid_q && (count_q == '1) && (bus.count == '0);

  // A write landing on the wrap edge bypasses the shadow register.
  assign next_cmp = bus.cmp_wr ? bus.cmp_val : shadow_q;

`ifdef CCU_WRAP_IRQ_EN
  assign irq_set = match_d | wrap_w;
`else
  assign irq_set = match_d;
`endif

  assign irq_d = irq_set | (irq_q & ~bus.irq_clr);

  // Next state and registered-output values of the period FSM.
  always_comb begin
    state_d = state_q;
    pwm_d   = 1'b0;
    match_d = 1'b0;
    if (!bus.enable) begin
      state_d = IDLE;
    end else if (wrap_w) begin
      if (next_cmp == '0) begin
        match_d = 1'b1;
        state_d = MATCHED;
      end else begin
        pwm_d   = 1'b1;
        state_d = ARMED;
      end
    end else begin
      unique case (state_q)
        IDLE: ;
        ARMED: begin
          if (bus.count == active_q) begin
            match_d = 1'b1;
            state_d = MATCHED;
          end else begin
            pwm_d = 1'b1;
          end
        end
        MATCHED: ;
        default: state_d = IDLE;
      endcase
    end
  end

  // All state and outputs advance on the edge where count is stable.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      count_q  <= '0;
      valid_q  <= 1'b0;
      shadow_q <= '0;
      active_q <= '0;
      wcnt_q   <= '0;
      pwm_q    <= 1'b0;
      match_q  <= 1'b0;
      wrap_q   <= 1'b0;
      irq_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= bus.count;
      valid_q <= 1'b1;
      pwm_q   <= pwm_d;
      match_q <= match_d;
      wrap_q  <= wrap_w;
      irq_q   <= irq_d;
      if (bus.cmp_wr) shadow_q <= bus.cmp_val;
      if (wrap_w) begin
        active_q <= next_cmp;
        wcnt_q   <= wcnt_q + 1'b1;
      end
    end
  end

  assign bus.pwm_out     = pwm_q;
  assign bus.match_pulse = match_q;
  assign bus.wrap_pulse  = wrap_q;
  assign bus.irq         = irq_q;
  assign bus.wrap_cnt    = wcnt_q;
  assign bus.cmp_active  = active_q;

endmodule

// File: tb/tb_count_compare_unit.sv
// Bench for count_compare_unit: reset table, PWM periods, shadow bypass,
// irq priority, upstream count reset and enable drop.
module tb_count_compare_unit;
  localparam int N      = 8;
  localparam int WRAP_W = 16;
`ifdef CCU_WRAP_IRQ_EN
  localparam bit WRAP_IRQ = 1'b1;
`else
  localparam bit WRAP_IRQ = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;

  count_compare_unit_if #(.N(N), .WRAP_W(WRAP_W)) bus ();

  count_compare_unit #(.N(N), .WRAP_W(WRAP_W)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        pwm;
    logic        mat;
    logic        wrp;
    logic        irq;
    logic [15:0] wcnt;
    logic [7:0]  act;
  } exp_t;

  typedef struct {
    logic       r;
    logic       en;
    logic       wr;
    logic [7:0] v;
    logic [7:0] c;
    exp_t       e;
  } vec_t;

  exp_t sbq[$];
  int   n_cmp  = 0;
  int   n_fail = 0;
  int   hi, nm, nw;
  logic [7:0] cnt;
  logic [15:0] wsave;

  logic [7:0]  m_cq, m_sh, m_act;
  logic        m_valid, m_pwm, m_mat, m_wr, m_irq;
  logic [15:0] m_wc;
  int          m_st;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h (count %0h)", name, act, exp, bus.count);
    end
  endfunction

  task automatic model(input logic r, en, wr, clr, input logic [7:0] c, v,
                       output exp_t e);
    logic       w;
    logic [7:0] nc;
    if (r) begin
      m_cq = 0; m_valid = 0; m_sh = 0; m_act = 0; m_wc = 0;
      m_st = 0; m_pwm = 0; m_mat = 0; m_wr = 0; m_irq = 0;
    end else begin
      w  = m_valid && (m_cq == 8'hFF) && (c == 8'h00);
      nc = wr ? v : m_sh;
      m_wr = w;
      if (w) m_wc = m_wc + 16'd1;
      m_mat = 0;
      m_pwm = 0;
      if (!en) m_st = 0;
      else if (w) begin
        if (nc == 8'h00) begin m_mat = 1; m_st = 2; end
        else begin m_pwm = 1; m_st = 1; end
      end else if (m_st == 1) begin
        if (c == m_act) begin m_mat = 1; m_st = 2; end
        else m_pwm = 1;
      end
      if (m_mat || (WRAP_IRQ && w)) m_irq = 1;
      else if (clr) m_irq = 0;
      if (w) m_act = nc;
      if (wr) m_sh = v;
      m_cq = c;
      m_valid = 1;
    end
    e.pwm = m_pwm; e.mat = m_mat; e.wrp = m_wr;
    e.irq = m_irq; e.wcnt = m_wc; e.act = m_act;
  endtask

  task automatic apply(input logic r, en, wr, clr, input logic [7:0] c, v,
                       input bit tab, input exp_t te);
    exp_t e, g;
    @(negedge clk);
    rst = r;
    bus.enable = en;
    bus.cmp_wr = wr;
    bus.cmp_val = v;
    bus.irq_clr = clr;
    bus.count = c;
    model(r, en, wr, clr, c, v, e);
    if (tab) sbq.push_back(te);
    else sbq.push_back(e);
    @(posedge clk);
    #1;
    g = sbq.pop_front();
    chk("pwm_out", 32'(bus.pwm_out), 32'(g.pwm));
    chk("match_pulse", 32'(bus.match_pulse), 32'(g.mat));
    chk("wrap_pulse", 32'(bus.wrap_pulse), 32'(g.wrp));
    chk("irq", 32'(bus.irq), 32'(g.irq));
    chk("wrap_cnt", 32'(bus.wrap_cnt), 32'(g.wcnt));
    chk("cmp_active", 32'(bus.cmp_active), 32'(g.act));
    hi += int'(bus.pwm_out);
    nm += int'(bus.match_pulse);
    nw += int'(bus.wrap_pulse);
  endtask

  task automatic tick(input logic en, wr, input logic [7:0] v, input logic clr);
    exp_t z;
    z = '{default: '0};
    apply(1'b0, en, wr, clr, cnt, v, 1'b0, z);
    cnt = cnt + 8'd1;
  endtask

  task automatic run_to(input logic en, input logic [7:0] stop);
    while (cnt != stop) tick(en, 1'b0, 8'h00, 1'b0);
  endtask

  task automatic run_period(input int wi, input logic [7:0] wv, input int ci,
                            input int exp_hi, input string name);
    hi = 0; nm = 0; nw = 0;
    for (int i = 0; i < 256; i++)
      tick(1'b1, i == wi, wv, i == ci);
    chk({name, "_high"}, 32'(hi), 32'(exp_hi));
    chk({name, "_match"}, 32'(nm), 32'd1);
    chk({name, "_wrap"}, 32'(nw), 32'd1);
  endtask

  vec_t tab[6];

  initial begin
    bus.enable = 0; bus.cmp_wr = 0; bus.cmp_val = 0;
    bus.irq_clr = 0; bus.count = 8'hFC;
    for (int i = 0; i < 6; i++) begin
      tab[i].r = 0; tab[i].en = 1; tab[i].wr = 0; tab[i].v = 0;
      tab[i].c = 8'hFC + 8'(i);
      tab[i].e = '{default: '0};
    end
    tab[0].r = 1; tab[0].en = 0;
    tab[1].r = 1; tab[1].en = 0;
    tab[2].en = 0;
    tab[3].wr = 1; tab[3].v = 8'h40;
    tab[4].e = '{pwm: 1, mat: 0, wrp: 1, irq: WRAP_IRQ, wcnt: 16'd1, act: 8'h40};
    tab[5].e = '{pwm: 1, mat: 0, wrp: 0, irq: WRAP_IRQ, wcnt: 16'd1, act: 8'h40};

    hi = 0; nm = 0; nw = 0;
    for (int i = 0; i < 6; i++) begin
      if (i == 4) begin hi = 0; nm = 0; nw = 0; end
      apply(tab[i].r, tab[i].en, tab[i].wr, 1'b0, tab[i].c, tab[i].v,
            1'b1, tab[i].e);
    end
    cnt = 8'h02;
    run_to(1'b1, 8'h00);
    chk("p40_high", 32'(hi), 32'd64);
    chk("p40_match", 32'(nm), 32'd1);
    chk("p40_irq", 32'(bus.irq), 32'd1);

    run_period(8'h20, 8'h00, -1, 64, "mid_wr_00");
    run_period(8'h20, 8'hFF, -1, 0, "cmp_00");
    run_period(8'h20, 8'h40, -1, 255, "cmp_ff");
    run_period(8'h20, 8'h80, -1, 64, "mid_wr_80");
    run_period(8'h20, 8'h40, -1, 128, "cmp_80");
    run_period(0, 8'h10, -1, 16, "bypass_10");
    run_period(-1, 8'h00, 8'h10, 16, "clr_on_match");
    chk("irq_set_wins", 32'(bus.irq), 32'd1);

    tick(1'b1, 1'b1, 8'hC0, 1'b0);
    chk("bypass_c0", 32'(bus.cmp_active), 32'hC0);
    tick(1'b1, 1'b0, 8'h00, 1'b1);
    chk("irq_clr", 32'(bus.irq), 32'd0);
    run_to(1'b1, 8'h91);
    wsave = bus.wrap_cnt;
    cnt = 8'h00;
    tick(1'b1, 1'b0, 8'h00, 1'b0);
    chk("up_rst_wrap", 32'(bus.wrap_pulse), 32'd0);
    chk("up_rst_wcnt", 32'(bus.wrap_cnt), 32'(wsave));
    chk("up_rst_pwm", 32'(bus.pwm_out), 32'd1);
    run_to(1'b1, 8'hF0);
    tick(1'b1, 1'b0, 8'h00, 1'b1);
    chk("irq_clr2", 32'(bus.irq), 32'd0);
    run_to(1'b1, 8'h00);
    tick(1'b1, 1'b0, 8'h00, 1'b0);
    chk("wrap_irq", 32'(bus.irq), 32'(WRAP_IRQ));
    chk("wrap_pwm", 32'(bus.pwm_out), 32'd1);
    run_to(1'b1, 8'h30);
    tick(1'b0, 1'b0, 8'h00, 1'b0);
    chk("en_drop_pwm", 32'(bus.pwm_out), 32'd0);
    run_to(1'b0, 8'h40);
    hi = 0;
    run_to(1'b1, 8'h00);
    chk("reen_idle_high", 32'(hi), 32'd0);
    tick(1'b1, 1'b0, 8'h00, 1'b0);
    chk("reen_resume", 32'(bus.pwm_out), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
